// File: rtl/fetch_unit_if.sv
// Fetch-to-memory and fetch-to-decoder bus: instruction memory address/data,
// branch redirect input and the valid/ready instruction output slot.
interface fetch_unit_if;
  logic [7:0] saidaInstrucao;
  logic [7:0] pccounter;
  logic       branch_taken;
  logic [7:0] branch_target;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] instr_opcode;
  logic [7:0] instr_imm;
  logic [7:0] instr_pc;

  modport master (
    input  saidaInstrucao, branch_taken, branch_target, instr_ready,
    output pccounter, instr_valid, instr_opcode, instr_imm, instr_pc
  );

  modport slave (
    output saidaInstrucao, branch_taken, branch_target, instr_ready,
    input  pccounter, instr_valid, instr_opcode, instr_imm, instr_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: assembles 1/2-byte instructions for the decoder.
// Define FETCH_JMP_EN to resolve JMP (3'b110) locally instead of presenting it.
module fetch_unit (
  input  logic          clock,
  input  logic          reset,
  fetch_unit_if.master  bus
);

  typedef enum logic {FETCH_OP, FETCH_IMM} state_t;

  state_t     state;
  logic [7:0] pc_q;
  logic [7:0] op_q;
  logic [7:0] imm_q;
  logic [7:0] ipc_q;
  logic       valid_q;

  logic       advance;
  logic       two_byte;

  assign advance  = !valid_q || bus.instr_ready;
  assign two_byte = (bus.saidaInstrucao[7:5] == 3'b000) ||
                    (bus.saidaInstrucao[7:5] == 3'b110);

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= FETCH_OP;
      pc_q    <= '0;
      op_q    <= '0;
      imm_q   <= '0;
      ipc_q   <= '0;
      valid_q <= 1'b0;
    end else if (bus.branch_taken) begin
      // Redirect drops both a half-built instruction and an unconsumed slot.
      state   <= FETCH_OP;
      pc_q    <= bus.branch_target;
      valid_q <= 1'b0;
    end else begin
      case (state)
        FETCH_OP: begin
          if (advance) begin
            op_q  <= bus.saidaInstrucao;
            ipc_q <= pc_q;
            pc_q  <= pc_q + 8'd1;
            if (two_byte) begin
              valid_q <= 1'b0;
              state   <= FETCH_IMM;
            end else begin
              imm_q   <= '0;
              valid_q <= 1'b1;
            end
          end
        end
        FETCH_IMM: begin
          imm_q <= bus.saidaInstrucao;
          state <= FETCH_OP;
`ifdef FETCH_JMP_EN
          if (op_q[7:5] == 3'b110) begin
            pc_q    <= bus.saidaInstrucao;
            valid_q <= 1'b0;
          end else begin
            pc_q    <= pc_q + 8'd1;
            valid_q <= 1'b1;
          end
`else
          pc_q    <= pc_q + 8'd1;
          valid_q <= 1'b1;
`endif
        end
        default: state <= FETCH_OP;
      endcase
    end
  end

  assign bus.pccounter    = pc_q;
  assign bus.instr_valid  = valid_q;
  assign bus.instr_opcode = op_q;
  assign bus.instr_imm    = imm_q;
  assign bus.instr_pc     = ipc_q;

endmodule
